call_scheduler: RTL

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/call_scheduler.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/call_scheduler.sv
// call_scheduler
// Collects landing (hall) and in-car (cab) calls into a registered pending
// bitmap and chooses the next destination for a downstream elevator
// controller. Travel is a collective sweep: keep going in the current
// direction while calls remain that way. After arrival, a timed door dwell
// follows. An emergency or an out-of-range floor report forces HALT.
//
// Optional feature (macro CALL_SCHED_EMER_FLUSH_EN):
//   defined   - entry to HALT clears every pending call, and calls are
//               ignored while halted.
//   undefined - pending calls survive HALT, new calls keep latching, and
//               service resumes from IDLE.
//
// o_dest_valid is a level, not a handshake. While it is high, o_dest_floor
// is the floor the car should travel to. The controller signals arrival by
// reporting i_cur_floor == o_dest_floor with i_moving low. No acknowledge is
// expected.
//
// o_state exposes the FSM state for debug.
module call_scheduler #(
  parameter int NUM_FLOORS  = 10,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_FLOORS-1:0] i_hall_call,
  input  logic [NUM_FLOORS-1:0] i_cab_call,
  input  logic [3:0]            i_cur_floor,
  input  logic                  i_moving,
  input  logic                  i_emergency,
  output logic [3:0]            o_dest_floor,
  output logic                  o_dest_valid,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up,
  output logic [2:0]            o_state
);

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DOOR_RELOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [4:0]    FLOORS_LIM  = 5'(NUM_FLOORS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_UP   = 3'd1,
    ST_SERVE_DOWN = 3'd2,
    ST_DOOR_OPEN  = 3'd3,
    ST_HALT       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   p_q, p_d;
  logic [3:0]              dest_q, dest_d;
  logic                    valid_q, valid_d;
  logic                    door_q, door_d;
  logic                    dir_q, dir_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [NUM_FLOORS-1:0]   call_v;
  logic [NUM_FLOORS-1:0]   calls_in;
  logic [NUM_FLOORS-1:0]   cur_oh;
  logic [NUM_FLOORS-1:0]   dest_oh;
  logic [NUM_FLOORS-1:0]   clr_mask;
  logic                    block_here;
  logic                    cur_ok;
  logic                    halt_req;
  logic                    at_cur;
  logic                    call_here;
  logic                    at_dest;
  logic                    arrived;
  logic                    up_hit, dn_hit;
  logic [3:0]              up_tgt, dn_tgt;

  assign call_v   = i_hall_call | i_cab_call;
  assign cur_ok   = ({1'b0, i_cur_floor} < FLOORS_LIM);
  assign halt_req = i_emergency | ~cur_ok;
  assign at_dest  = (i_cur_floor == dest_q);
  assign arrived  = at_dest & ~i_moving;

  // Floor decode. Finds the nearest pending floor above and below the car.
  // The up scan runs from the top down, so the lowest floor above wins. The
  // down scan runs from the bottom up, so the highest floor below wins.
  always_comb begin
    cur_oh  = '0;
    dest_oh = '0;
    up_hit  = 1'b0;
    up_tgt  = '0;
    dn_hit  = 1'b0;
    dn_tgt  = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (p_q[f] && (f > int'(i_cur_floor))) begin
        up_hit = 1'b1;
        up_tgt = 4'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (p_q[f] && (f < int'(i_cur_floor))) begin
        dn_hit = 1'b1;
        dn_tgt = 4'(f);
      end
      if (f == int'(i_cur_floor)) cur_oh[f] = 1'b1;
      if (f == int'(dest_q))      dest_oh[f] = 1'b1;
    end
    at_cur    = |(p_q & cur_oh);
    call_here = |(call_v & cur_oh);
  end

  // Next-state and next-output logic. Halt requests override everything.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    valid_d    = valid_q;
    door_d     = 1'b0;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    clr_mask   = '0;
    block_here = 1'b0;
    calls_in   = call_v;
    p_d        = p_q;

    if (halt_req) begin
      state_d = ST_HALT;
      dest_d  = i_cur_floor;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dest_d  = i_cur_floor;
          valid_d = 1'b0;
          if (at_cur) begin
            // A call at the car's own floor is served before any travel.
            state_d  = ST_DOOR_OPEN;
            clr_mask = cur_oh;
            cnt_d    = DOOR_RELOAD;
            door_d   = ~i_moving;
          end else if (up_hit && (!dn_hit || dir_q)) begin
            state_d = ST_SERVE_UP;
            dest_d  = up_tgt;
            valid_d = 1'b1;
            dir_d   = 1'b1;
          end else if (dn_hit) begin
            state_d = ST_SERVE_DOWN;
            dest_d  = dn_tgt;
            valid_d = 1'b1;
            dir_d   = 1'b0;
          end
        end

        ST_SERVE_UP, ST_SERVE_DOWN: begin
          if (arrived) begin
            state_d  = ST_DOOR_OPEN;
            clr_mask = dest_oh;
            dest_d   = i_cur_floor;
            valid_d  = 1'b0;
            cnt_d    = DOOR_RELOAD;
            door_d   = 1'b1;
          end else if (at_dest) begin
            // The car is settling at the target landing. Keep the target so
            // the car does not chase the next call.
            valid_d = 1'b1;
          end else if ((state_q == ST_SERVE_UP) && up_hit) begin
            dest_d  = up_tgt;
            valid_d = 1'b1;
            dir_d   = 1'b1;
          end else if ((state_q == ST_SERVE_DOWN) && dn_hit) begin
            dest_d  = dn_tgt;
            valid_d = 1'b1;
            dir_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            dest_d  = i_cur_floor;
            valid_d = 1'b0;
          end
        end

        ST_DOOR_OPEN: begin
          dest_d  = i_cur_floor;
          valid_d = 1'b0;
          if (call_here) begin
            // A press at this landing extends the dwell. It is not queued.
            block_here = 1'b1;
            cnt_d      = DOOR_RELOAD;
            door_d     = ~i_moving;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q - CW'(1);
            door_d = ~i_moving;
          end
        end

        ST_HALT: begin
          state_d = ST_IDLE;
          dest_d  = i_cur_floor;
          valid_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          dest_d  = i_cur_floor;
          valid_d = 1'b0;
        end
      endcase
    end

    if (block_here) calls_in = call_v & ~cur_oh;

`ifdef CALL_SCHED_EMER_FLUSH_EN
    if (halt_req && (state_q != ST_HALT)) begin
      p_d = '0;
    end else if (state_q == ST_HALT) begin
      p_d = p_q;
    end else begin
      p_d = (p_q | calls_in) & ~clr_mask;
    end
`else
    p_d = (p_q | calls_in) & ~clr_mask;
`endif
  end

  // State and output registers. A synchronous active-low reset drops every
  // pending call, including calls asserted during reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      dest_q  <= '0;
      valid_q <= 1'b0;
      door_q  <= 1'b0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
      door_q  <= door_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_dest_floor = dest_q;
  assign o_dest_valid = valid_q;
  assign o_door_open  = door_q;
  assign o_pending    = p_q;
  assign o_dir_up     = dir_q;
  assign o_state      = state_q;

endmodule
